// File: rtl/mac_package.sv
// Shared TCDM constants and response types for the MAC streamer test memory.
package mac_package;
  localparam int TCDM_DW     = 32;
  localparam int TCDM_BE_W   = TCDM_DW / 8;
  localparam int MP_MAX      = 8;
  localparam int TCDM_PORT_W = $clog2(MP_MAX);
  localparam logic [TCDM_DW-1:0] OOB_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                   valid;
    logic [TCDM_PORT_W-1:0] port;
    logic [TCDM_DW-1:0]     rdata;
  } tcdm_resp_t;
endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// Single TCDM request/response channel between a master and a memory slave.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/mac_tcdm_rr_arbiter.sv
// Round-robin single-grant arbiter; pointer moves just past the last winner.
module mac_tcdm_rr_arbiter #(
  parameter  int MP = 4,
  localparam int PW = (MP > 1) ? $clog2(MP) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic [MP-1:0] req,
  input  logic          stall,
  output logic [MP-1:0] gnt,
  output logic [PW-1:0] winner,
  output logic          gnt_any
);
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [PW-1:0] cand;
    gnt     = '0;
    winner  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (!stall) begin
      for (int i = 0; i < MP; i++) begin
        cand = PW'((int'(ptr_q) + i) % MP);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          winner  = cand;
        end
      end
    end
    if (gnt_any) gnt[winner] = 1'b1;
    ptr_d = gnt_any ? PW'((int'(winner) + 1) % MP) : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) ptr_q <= '0;
    else                  ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mac_tcdm_responder.sv
// TCDM memory-bank model: RR-arbitrated word memory with fixed-latency responses.
module mac_tcdm_responder
  import mac_package::*;
#(
  parameter  int MP    = 4,
  parameter  int DEPTH = 1024,
  parameter  int LAT   = 1,
  localparam int PW    = (MP > 1) ? $clog2(MP) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        stall_i,
  hwpe_stream_intf_tcdm.slave tcdm [MP-1:0],
  output logic [31:0] nb_reads_o,
  output logic [31:0] nb_writes_o,
  output logic        oob_o
);
  logic [MP-1:0]                req, wen, gnt, resp_hit;
  logic [MP-1:0][31:0]          add, wdata;
  logic [MP-1:0][TCDM_BE_W-1:0] be;
  logic [PW-1:0]                winner;
  logic                         gnt_any;

  tcdm_resp_t                   pipe [LAT];
  tcdm_resp_t                   resp_out;
  logic [TCDM_DW-1:0]           mem  [DEPTH];

  logic                 sel_wen, sel_oob;
  logic [31:0]          sel_add, sel_data;
  logic [TCDM_BE_W-1:0] sel_be;
  logic [AW-1:0]        sel_idx;
  logic [TCDM_DW-1:0]   rd_data;
  logic                 unused_addr_lsb;

  assign resp_out = pipe[LAT-1];

  for (genvar p = 0; p < MP; p++) begin : g_port
    assign req[p]           = tcdm[p].req;
    assign wen[p]           = tcdm[p].wen;
    assign add[p]           = tcdm[p].add;
    assign be[p]            = tcdm[p].be;
    assign wdata[p]         = tcdm[p].data;
    assign tcdm[p].gnt      = gnt[p];
    assign resp_hit[p]      = resp_out.valid && (resp_out.port == TCDM_PORT_W'(p));
    assign tcdm[p].r_valid  = resp_hit[p];
    assign tcdm[p].r_data   = resp_hit[p] ? resp_out.rdata : '0;
  end

  // Reset and clear also suppress grants so nothing lands during a flush.
  mac_tcdm_rr_arbiter #(.MP(MP)) i_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .req     (req),
    .stall   (stall_i | rst_i | clear_i),
    .gnt     (gnt),
    .winner  (winner),
    .gnt_any (gnt_any)
  );

  assign sel_wen         = wen[winner];
  assign sel_add         = add[winner];
  assign sel_be          = be[winner];
  assign sel_data        = wdata[winner];
  assign sel_idx         = sel_add[AW+1:2];
  assign sel_oob         = (sel_add >> (AW + 2)) != 32'd0;
  assign unused_addr_lsb = ^sel_add[1:0];

  always_comb begin
    rd_data = '0;
    if (gnt_any && sel_wen) rd_data = sel_oob ? OOB_RDATA : mem[sel_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (gnt_any && !sel_wen && !sel_oob) begin
      for (int b = 0; b < TCDM_BE_W; b++)
        if (sel_be[b]) mem[sel_idx][8*b +: 8] <= sel_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
      nb_reads_o  <= '0;
      nb_writes_o <= '0;
      oob_o       <= 1'b0;
    end else begin
      pipe[0] <= '{valid: gnt_any, port: TCDM_PORT_W'(winner), rdata: rd_data};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      if (gnt_any) begin
        if (sel_wen) nb_reads_o  <= nb_reads_o + 32'd1;
        else         nb_writes_o <= nb_writes_o + 32'd1;
        if (sel_oob) oob_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_tcdm_responder.sv
// Bench: directed + random traffic on a LAT=1 instance checked against a queue model,
// plus a LAT=3 instance exercising reset during an in-flight read.
module tb_mac_tcdm_responder;
  localparam int MP = 4, DEPTH = 1024, LAT = 1, LATB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, stall, rst_b, clr_b, stall_b;
  logic [MP-1:0]       req_a, wen_a, gnt_a, rv_a, req_b, wen_b, gnt_b, rv_b;
  logic [MP-1:0][31:0] add_a, data_a, rd_a, add_b, data_b, rd_b;
  logic [MP-1:0][3:0]  be_a, be_b;
  logic [31:0]         nbr_a, nbw_a, nbr_b, nbw_b;
  logic                oob_a, oob_b;

  hwpe_stream_intf_tcdm tcdm_a [MP-1:0] ();
  hwpe_stream_intf_tcdm tcdm_b [MP-1:0] ();

  for (genvar g = 0; g < MP; g++) begin : g_wire
    assign tcdm_a[g].req  = req_a[g];
    assign tcdm_a[g].wen  = wen_a[g];
    assign tcdm_a[g].add  = add_a[g];
    assign tcdm_a[g].be   = be_a[g];
    assign tcdm_a[g].data = data_a[g];
    assign gnt_a[g]       = tcdm_a[g].gnt;
    assign rv_a[g]        = tcdm_a[g].r_valid;
    assign rd_a[g]        = tcdm_a[g].r_data;
    assign tcdm_b[g].req  = req_b[g];
    assign tcdm_b[g].wen  = wen_b[g];
    assign tcdm_b[g].add  = add_b[g];
    assign tcdm_b[g].be   = be_b[g];
    assign tcdm_b[g].data = data_b[g];
    assign gnt_b[g]       = tcdm_b[g].gnt;
    assign rv_b[g]        = tcdm_b[g].r_valid;
    assign rd_b[g]        = tcdm_b[g].r_data;
  end

  mac_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .LAT(LAT)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .stall_i(stall), .tcdm(tcdm_a),
    .nb_reads_o(nbr_a), .nb_writes_o(nbw_a), .oob_o(oob_a));

  mac_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .LAT(LATB)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .clear_i(clr_b), .stall_i(stall_b), .tcdm(tcdm_b),
    .nb_reads_o(nbr_b), .nb_writes_o(nbw_b), .oob_o(oob_b));

  // Behavioural model of instance A
  typedef struct { int due; int port; logic [31:0] data; } rsp_t;
  logic [31:0] mmem [DEPTH];
  int unsigned m_nr, m_nw;
  bit          m_oob;
  int          m_ptr, cyc;
  rsp_t        rq [$];
  int          total = 0, bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset(bit with_mem);
    if (with_mem) foreach (mmem[i]) mmem[i] = '0;
    m_nr = 0; m_nw = 0; m_oob = 0; m_ptr = 0;
    rq.delete();
  endtask

  // Compares every output of A against the model, then advances the model past the edge.
  task automatic sample();
    int w, p;
    logic [31:0] a, d, erd;
    logic [3:0] eg;
    bit erv, oob;
    @(negedge clk);
    w = -1;
    if (!rst && !clr && !stall)
      for (int i = 0; i < MP; i++) begin
        p = (m_ptr + i) % MP;
        if (w < 0 && req_a[p]) w = p;
      end
    eg = (w >= 0) ? 4'(1 << w) : 4'd0;
    chk("gnt", 32'(gnt_a), 32'(eg));
    for (int q = 0; q < MP; q++) begin
      erv = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].port == q);
      erd = erv ? rq[0].data : 32'd0;
      chk($sformatf("r_valid%0d", q), 32'(rv_a[q]), 32'(erv));
      chk($sformatf("r_data%0d", q), rd_a[q], erd);
    end
    chk("nb_reads", nbr_a, m_nr);
    chk("nb_writes", nbw_a, m_nw);
    chk("oob", 32'(oob_a), 32'(m_oob));
    if (rst) model_reset(1);
    else if (clr) model_reset(0);
    else begin
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (w >= 0) begin
        a   = add_a[w];
        oob = a >= 32'(4 * DEPTH);
        if (wen_a[w]) begin
          d = oob ? 32'hDEAD_BEEF : mmem[a >> 2];
          m_nr++;
        end else begin
          d = 32'd0;
          m_nw++;
          if (!oob)
            for (int b = 0; b < 4; b++)
              if (be_a[w][b]) mmem[a >> 2][8*b +: 8] = data_a[w][8*b +: 8];
        end
        if (oob) m_oob = 1;
        rq.push_back('{cyc + LAT, w, d});
        m_ptr = (w + 1) % MP;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = '0; wen_a = '0; add_a = '0; be_a = '0; data_a = '0;
    rst = 0; clr = 0; stall = 0;
  endtask

  task automatic drv(int p, bit rd, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    req_a[p] = 1'b1; wen_a[p] = rd; add_a[p] = a; be_a[p] = b; data_a[p] = d;
  endtask

  task automatic drvb(bit rd, logic [31:0] a, logic [31:0] d);
    req_b = 4'b0001; wen_b[0] = rd; add_b[0] = a; be_b[0] = 4'hF; data_b[0] = d;
  endtask

  task automatic idleb();
    req_b = '0; wen_b = '0; add_b = '0; be_b = '0; data_b = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    int unsigned widx;
    r = $urandom_range(0, 9);
    if (r < 7)      widx = $urandom_range(0, 15);
    else if (r < 9) widx = $urandom_range(DEPTH - 4, DEPTH - 1);
    else            widx = DEPTH + $urandom_range(0, 4095);
    return (32'(widx) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    idle(); rst = 1;
    idleb(); rst_b = 1; clr_b = 0; stall_b = 0;
    cyc = 0;
    model_reset(1);
    @(posedge clk); @(posedge clk); #1;

    sample();
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_nbr", nbr_a, 32'd0);
    chk("rst_oob", 32'(oob_a), 32'd0);
    step();

    // write then read back @0x10
    idle(); drv(0, 0, 32'h10, 4'hF, 32'h1234_5678); sample();
    chk("t1_wr_gnt", 32'(gnt_a), 32'h1); step();
    idle(); drv(0, 1, 32'h10, 4'h0, 32'h0); sample();
    chk("t1_rd_gnt", 32'(gnt_a), 32'h1); step();
    idle(); sample();
    chk("t1_rv", 32'(rv_a), 32'h1);
    chk("t1_rd", rd_a[0], 32'h1234_5678);
    chk("t1_nbw", nbw_a, 32'd1);
    chk("t1_nbr", nbr_a, 32'd1);
    step();

    // byte merge @0x20
    idle(); drv(0, 0, 32'h20, 4'hF, 32'hFFFF_FFFF); sample(); step();
    idle(); drv(0, 0, 32'h20, 4'b0001, 32'h0000_00AB); sample(); step();
    idle(); drv(0, 1, 32'h20, 4'h0, 32'h0); sample(); step();
    idle(); sample();
    chk("t2_merge", rd_a[0], 32'hFFFF_FFAB); step();

    // clear to reset pointer, then all four ports request for 8 cycles
    idle(); clr = 1; sample(); step();
    for (int k = 0; k < 8; k++) begin
      idle();
      for (int p = 0; p < MP; p++) drv(p, 1, 32'h40 + 32'(4 * p), 4'h0, 32'h0);
      sample();
      chk($sformatf("t3_gnt%0d", k), 32'(gnt_a), 32'(1 << (k % 4)));
      if (k > 0) chk($sformatf("t3_rv%0d", k), 32'(rv_a), 32'(1 << ((k - 1) % 4)));
      step();
    end
    idle(); sample();
    chk("t3_rv_last", 32'(rv_a), 32'h8); step();

    // stall port2 three cycles
    for (int k = 0; k < 3; k++) begin
      idle(); stall = 1; drv(2, 1, 32'h10, 4'h0, 32'h0); sample();
      chk($sformatf("t4_stall%0d", k), 32'(gnt_a), 32'h0); step();
    end
    idle(); drv(2, 1, 32'h10, 4'h0, 32'h0); sample();
    chk("t4_gnt", 32'(gnt_a), 32'h4); step();
    idle(); for (int p = 0; p < MP; p++) drv(p, 1, 32'h10, 4'h0, 32'h0); sample();
    chk("t4_rd", rd_a[2], 32'h1234_5678);
    chk("t4_ptr", 32'(gnt_a), 32'h8); step();
    idle(); sample(); step();

    // out of range, then clear
    idle(); drv(1, 1, 32'(4 * DEPTH), 4'h0, 32'h0); sample(); step();
    idle(); sample();
    chk("t5_oob_rd", rd_a[1], 32'hDEAD_BEEF);
    chk("t5_oob", 32'(oob_a), 32'h1); step();
    idle(); sample(); step();
    idle(); sample();
    chk("t5_oob_sticky", 32'(oob_a), 32'h1); step();
    idle(); clr = 1; sample(); step();
    idle(); sample();
    chk("t5_clr_oob", 32'(oob_a), 32'h0);
    chk("t5_clr_nbr", nbr_a, 32'h0);
    chk("t5_clr_nbw", nbw_a, 32'h0); step();
    idle(); drv(0, 1, 32'h10, 4'h0, 32'h0); sample(); step();
    idle(); sample();
    chk("t5_mem_kept", rd_a[0], 32'h1234_5678); step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      for (int p = 0; p < MP; p++)
        if ($urandom_range(0, 99) < 50)
          drv(p, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom);
      stall = $urandom_range(0, 99) < 15;
      clr   = $urandom_range(0, 99) < 2;
      rst   = $urandom_range(0, 199) == 0;
      sample();
      step();
    end
    idle(); sample(); step();

    // LAT=3 instance: reset one cycle after an in-flight read
    rst_b = 0; idleb();
    drvb(0, 32'h10, 32'hCAFE_0001); @(negedge clk);
    chk("b_wr_gnt", 32'(gnt_b), 32'h1); step();
    drvb(1, 32'h10, 32'h0); @(negedge clk);
    chk("b_rd_gnt", 32'(gnt_b), 32'h1); step();
    idleb(); rst_b = 1; @(negedge clk);
    chk("b_rv_rst", 32'(rv_b), 32'h0); step();
    rst_b = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("b_no_rv%0d", k), 32'(rv_b), 32'h0); step();
    end
    drvb(1, 32'h10, 32'h0); @(negedge clk);
    chk("b_rd2_gnt", 32'(gnt_b), 32'h1); step();
    idleb();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("b_lat%0d", k), 32'(rv_b), 32'h0); step();
    end
    @(negedge clk);
    chk("b_rv", 32'(rv_b), 32'h1);
    chk("b_rd_zero", rd_b[0], 32'h0);
    chk("b_nbr", nbr_b, 32'h1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
